// File: rtl/fault_campaign_sequencer.sv
// Fault-injection campaign sequencer.
// Sweeps fault IDs 0..NUM_FAULTS-1. For each ID it waits a trigger delay, pulses
// the fault enable for a programmed length, then observes a post-fault window.
// Golden/faulty result mismatches are counted over the inject+observe window and
// reported through a valid/ready handshake.
module fault_campaign_sequencer #(
  parameter int NUM_FAULTS = 4,
  parameter int CNT_W      = 8,
  parameter int OBS_WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] trig_delay,
  input  logic [CNT_W-1:0] inject_len,
  input  logic [31:0]      golden_result,
  input  logic [31:0]      faulty_result,
  input  logic             compare_en,
  output logic             fault_en,
  output logic [2:0]       fault_id,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [2:0]       rpt_fault_id,
  output logic [CNT_W-1:0] rpt_mismatch_cnt,
  output logic [CNT_W-1:0] rpt_first_cycle,
  output logic             done
);

  // Phase counter must hold both the CNT_W delays and OBS_WINDOW-1.
  localparam int OBS_W = $clog2(OBS_WINDOW + 1);
  localparam int PH_W  = (CNT_W > OBS_W) ? CNT_W : OBS_W;
  localparam logic [PH_W-1:0] OBS_LAST = PH_W'(OBS_WINDOW - 1);
  localparam logic [2:0]      LAST_ID  = 3'(NUM_FAULTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_INJECT, S_OBSERVE, S_REPORT, S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  trig_delay_q;
  logic [CNT_W-1:0]  inject_len_q;
  logic [PH_W-1:0]   ph_cnt;
  logic [CNT_W-1:0]  win_idx;
  logic [CNT_W-1:0]  mismatch_cnt;
  logic [CNT_W-1:0]  first_idx;
  logic              first_seen;

  logic              cmp_hit;
  logic [CNT_W-1:0]  mismatch_cnt_nxt;
  logic [CNT_W-1:0]  first_idx_nxt;
  logic              first_seen_nxt;

  // Saturating increment shared by the window index and the mismatch counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Moore outputs decoded straight from the state register, so reset clears them asynchronously.
  assign fault_en  = (state == S_INJECT);
  assign busy      = (state != S_IDLE);
  assign rpt_valid = (state == S_REPORT);
  assign done      = (state == S_DONE);

  // Comparison statistics as they will stand after this cycle, so the last observe cycle reaches the report.
  always_comb begin
    cmp_hit          = 1'b0;
    mismatch_cnt_nxt = mismatch_cnt;
    first_idx_nxt    = first_idx;
    first_seen_nxt   = first_seen;
    if ((state == S_INJECT || state == S_OBSERVE) && compare_en &&
        (golden_result != faulty_result)) begin
      cmp_hit          = 1'b1;
      mismatch_cnt_nxt = sat_inc(mismatch_cnt);
      first_seen_nxt   = 1'b1;
      if (!first_seen) begin
        first_idx_nxt = win_idx;
      end
    end
  end

  // Campaign FSM together with its counters, latched trigger settings and report registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      trig_delay_q     <= '0;
      inject_len_q     <= '0;
      ph_cnt           <= '0;
      win_idx          <= '0;
      mismatch_cnt     <= '0;
      first_idx        <= '0;
      first_seen       <= 1'b0;
      fault_id         <= '0;
      rpt_fault_id     <= '0;
      rpt_mismatch_cnt <= '0;
      rpt_first_cycle  <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            trig_delay_q <= trig_delay;
            inject_len_q <= (inject_len == '0) ? CNT_W'(1) : inject_len;
            fault_id     <= '0;
            state        <= S_ARM;
          end
        end
        S_ARM: begin
          win_idx      <= '0;
          mismatch_cnt <= '0;
          first_idx    <= '0;
          first_seen   <= 1'b0;
          if (trig_delay_q == '0) begin
            ph_cnt <= PH_W'(inject_len_q) - PH_W'(1);
            state  <= S_INJECT;
          end else begin
            ph_cnt <= PH_W'(trig_delay_q) - PH_W'(1);
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ph_cnt == '0) begin
            ph_cnt <= PH_W'(inject_len_q) - PH_W'(1);
            state  <= S_INJECT;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
        S_INJECT: begin
          win_idx      <= sat_inc(win_idx);
          mismatch_cnt <= mismatch_cnt_nxt;
          first_idx    <= first_idx_nxt;
          first_seen   <= first_seen_nxt;
          if (ph_cnt == '0) begin
            ph_cnt <= OBS_LAST;
            state  <= S_OBSERVE;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
        S_OBSERVE: begin
          win_idx      <= sat_inc(win_idx);
          mismatch_cnt <= mismatch_cnt_nxt;
          first_idx    <= first_idx_nxt;
          first_seen   <= first_seen_nxt;
          if (ph_cnt == '0) begin
            rpt_fault_id     <= fault_id;
            rpt_mismatch_cnt <= mismatch_cnt_nxt;
            rpt_first_cycle  <= first_seen_nxt ? first_idx_nxt : {CNT_W{1'b1}};
            state            <= S_REPORT;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
        S_REPORT: begin
          if (rpt_ready) begin
            if (fault_id == LAST_ID) begin
              state <= S_DONE;
            end else begin
              fault_id <= fault_id + 3'd1;
              state    <= S_ARM;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fault_campaign_sequencer.md
Name: fault_campaign_sequencer

Overview:
- Sequences a fault-injection campaign on the faulty RISC-V datapath (ALU/control-unit fault sites).
- For each fault ID 0..NUM_FAULTS-1, it:
  - waits a programmed trigger delay,
  - asserts the fault enable for a programmed length,
  - observes a post-fault window,
  - compares faulty-datapath results against the golden datapath,
  - reports the mismatch statistics over a valid/ready handshake.
- Sits between the testbench/host and the fault-select inputs of the faulty datapath wrapper.

Parameters:
- NUM_FAULTS, 4, number of fault IDs swept per campaign (1..8).
- CNT_W, 8, width of the delay, length and statistics counters.
- OBS_WINDOW, 16, post-injection observation cycles (>=1).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- start  input  1  campaign start pulse; honoured only in IDLE
- abort  input  1  synchronous abort; returns to IDLE from any state
- trig_delay  input  CNT_W  cycles between ARM and injection; latched at start
- inject_len  input  CNT_W  fault-active cycles; latched at start; 0 treated as 1
- golden_result  input  32  result from the fault-free datapath
- faulty_result  input  32  result from the faulty datapath
- compare_en  input  1  both results valid this cycle
- fault_en  output  1  fault activation to the datapath wrapper
- fault_id  output  3  currently selected fault site
- busy  output  1  high in every state except IDLE
- rpt_valid  output  1  report available
- rpt_ready  input  1  report consumer ready
- rpt_fault_id  output  3  fault ID of the report
- rpt_mismatch_cnt  output  CNT_W  mismatching compare cycles; saturating
- rpt_first_cycle  output  CNT_W  window index of the first mismatch; all-ones if none
- done  output  1  one-cycle pulse at campaign end

Behaviour:

Reset (rst low):
- State goes to IDLE.
- All outputs are 0.
- All internal counters and latches are 0.

States: IDLE, ARM, WAIT, INJECT, OBSERVE, REPORT, DONE.
- IDLE:
  - start=1 latches trig_delay and inject_len (0 becomes 1), sets fault_id=0, and moves to ARM.
- ARM (1 cycle):
  - Clears mismatch_cnt, win_idx and the first-seen flag.
  - Moves to INJECT if the latched trig_delay is 0, else to WAIT.
- WAIT:
  - Lasts exactly trig_delay cycles, then moves to INJECT.
- INJECT:
  - Lasts exactly inject_len cycles.
  - fault_en=1 only while in INJECT (Moore output decoded from the state register).
  - Moves to OBSERVE.
- OBSERVE:
  - Lasts exactly OBS_WINDOW cycles with fault_en=0.
  - Moves to REPORT.
- REPORT:
  - rpt_valid=1.
  - rpt_* outputs are loaded on entry and held stable until the cycle where rpt_valid and rpt_ready are both high.
  - After the handshake, moves to DONE if fault_id==NUM_FAULTS-1; otherwise increments fault_id and moves to ARM.
  - rpt_ready asserted on the entry cycle completes the handshake in that same cycle, so the minimum REPORT dwell is 1 cycle.
- DONE:
  - done=1 for exactly 1 cycle, then moves to IDLE.
  - fault_id holds its last value until the next start.

Comparison:
- Active in INJECT and OBSERVE only.
- win_idx is 0 in the first INJECT cycle and increments every cycle, saturating at all-ones.
- A mismatch is counted when compare_en=1 and golden_result != faulty_result.
- mismatch_cnt increments on each mismatch, saturating at 2^CNT_W-1.
- The first mismatch captures win_idx into the first-cycle register.
- If no mismatch occurred, rpt_first_cycle reports all-ones.

Other rules:
- start outside IDLE is ignored, with no re-latch.
- abort has priority over start and every transition:
  - Next state is IDLE.
  - fault_en, rpt_valid and busy drop in the next cycle.
  - No report and no done pulse are produced.
  - start and abort together in IDLE leave the block in IDLE.
- fault_id is constant during ARM..REPORT of each fault.
- The trigger inputs are not re-sampled during the campaign.
- Reset during any state forces IDLE immediately and deasserts fault_en asynchronously.

Test Plan:
1. Basic sweep, no mismatches:
   - Stimulus: NUM_FAULTS=4, trig_delay=3, inject_len=2, golden==faulty always, rpt_ready=1.
   - Required response:
     - 4 reports with IDs 0,1,2,3, each with mismatch_cnt=0 and first_cycle=0xFF.
     - fault_en high exactly 2 cycles per fault, starting 4 cycles after ARM.
     - done pulses once.
2. Mismatch statistics:
   - Stimulus: trig_delay=0, inject_len=5, faulty differs from golden on window cycles 2,3 and 10, compare_en=1.
   - Required response: rpt_mismatch_cnt=3, rpt_first_cycle=2.
   - A mismatch with compare_en=0 is not counted.
3. Report backpressure:
   - Stimulus: rpt_ready held low 7 cycles in REPORT.
   - Required response: rpt_valid and all rpt_* fields stable for all 7 cycles; the next fault's ARM starts the cycle after the handshake.
4. Saturation:
   - Stimulus: inject_len=255, mismatch on every cycle.
   - Required response: rpt_mismatch_cnt=255 (no wrap), rpt_first_cycle=0.
5. Abort and restart:
   - Stimulus: abort in INJECT.
   - Required response: fault_en=0 and busy=0 the next cycle, no rpt_valid, no done.
   - A subsequent start runs a full fresh campaign from fault_id=0.
6. Async reset mid-OBSERVE, and ignored start:
   - Stimulus: rst low mid-OBSERVE.
   - Required response: all outputs 0 immediately.
   - Stimulus: start pulsed during WAIT with different trig_delay/inject_len values.
   - Required response: the latched values are unchanged.
